// File: rtl/apb_arb_pkg.sv
// Shared types and bus geometry for the two-requester APB master.
// Imported by the arbiter core and its round-robin helper.
package apb_arb_pkg;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int STRB_W  = 2;
  localparam int N_REQ   = 2;
  localparam int SEL_BIT = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with its own last-grant pointer.
// The pointer resets to 1 so requester 0 wins the first contention.
import apb_arb_pkg::*;

module rr_arb2 (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] i_valid,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_ptr_nxt
);

  logic             r_ptr;
  logic [N_REQ-1:0] w_gnt;

  always_comb begin
    w_gnt = '0;
    unique case (i_valid)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = r_ptr ? 2'b01 : 2'b10;
      default: w_gnt = '0;
    endcase
  end

  assign o_gnt     = i_en ? w_gnt : '0;
  assign o_ptr_nxt = (|o_gnt) ? o_gnt[1] : r_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= 1'b1;
    end else begin
      r_ptr <= o_ptr_nxt;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// APB3/APB4 master serving two internal requesters round-robin.
// One transfer in flight; errors and timeouts return to the owner.
import apb_arb_pkg::*;

module apb_req_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        rq_valid,
  input  logic [N_REQ-1:0]        rq_write,
  input  logic [N_REQ*ADDR_W-1:0] rq_addr,
  input  logic [N_REQ*DATA_W-1:0] rq_wdata,
  input  logic [N_REQ*STRB_W-1:0] rq_strb,
  output logic [N_REQ-1:0]        rq_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [N_REQ-1:0]        psel,
  output logic                    penable,
  output logic [ADDR_W-1:0]       paddr,
  output logic [DATA_W-1:0]       pwdata,
  output logic                    pwrite,
  output logic [STRB_W-1:0]       pstrb,
  input  logic [DATA_W-1:0]       prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  state_e r_state;
  state_e w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_strb;
  logic              r_write;
  logic              r_gidx;
  logic [TO_W-1:0]   r_cnt;

  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic [N_REQ-1:0]  w_gnt;
  logic              w_gidx;
  logic              w_take;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_strb;
  logic              w_write;
  logic [TO_W-1:0]   w_cnt_inc;
  logic              w_tmo;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_valid   (rq_valid),
    .i_en      (r_state == ST_IDLE),
    .o_gnt     (w_gnt),
    .o_ptr_nxt (w_gidx)
  );

  assign w_take  = |w_gnt;
  assign w_addr  = w_gnt[1] ? rq_addr[2*ADDR_W-1:ADDR_W]
                            : rq_addr[ADDR_W-1:0];
  assign w_wdata = w_gnt[1] ? rq_wdata[2*DATA_W-1:DATA_W]
                            : rq_wdata[DATA_W-1:0];
  assign w_strb  = w_gnt[1] ? rq_strb[2*STRB_W-1:STRB_W]
                            : rq_strb[STRB_W-1:0];
  assign w_write = w_gnt[1] ? rq_write[1] : rq_write[0];

  // w_cnt_inc is the number of ACCESS cycles seen, including this one
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tmo     = !pready && (w_cnt_inc == TO_W'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_take) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready || w_tmo) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_write     <= 1'b0;
      r_gidx      <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      if (w_take) begin
        r_addr  <= w_addr;
        r_write <= w_write;
        r_gidx  <= w_gidx;
        r_wdata <= w_write ? w_wdata : '0;
        r_strb  <= w_write ? w_strb : '0;
        r_cnt   <= '0;
      end
      if (r_state == ST_ACCESS) begin
        if (pready) begin
          r_rsp_valid <= onehot2(r_gidx);
          r_rsp_err   <= pslverr;
          r_rsp_rdata <= r_write ? '0 : prdata;
        end else if (w_tmo) begin
          r_rsp_valid <= onehot2(r_gidx);
          r_rsp_err   <= 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign rq_ready  = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign psel    = (r_state == ST_IDLE) ? '0 : onehot2(r_addr[SEL_BIT]);
  assign penable = (r_state == ST_ACCESS);
  assign paddr   = r_addr;
  assign pwdata  = r_wdata;
  assign pwrite  = r_write;
  assign pstrb   = r_strb;

endmodule
